// File: rtl/mu0_regfile_pkg.sv
// -----------------------------------------------------------------------------
// mu0_regfile_pkg
// Shared types and defaults for the MU0 register file slice.
//   dump_state_t : dump engine states (IDLE, DUMP)
//   DEF_*        : default WIDTH / DEPTH / INC_STEP
//   addr_width() : address width for a given depth, never below 1 bit
// -----------------------------------------------------------------------------
package mu0_regfile_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    DUMP = 1'b1
  } dump_state_t;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_DEPTH    = 8;
  localparam int DEF_INC_STEP = 1;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mu0_regfile_if.sv
// -----------------------------------------------------------------------------
// mu0_regfile_if
// Bus between the MU0 control unit (master) and the register file (slave).
//   Write     : WrEn, WrAddr, WrData
//   Increment : IncEn, IncAddr
//   Read A/B  : RdAddrA/RdDataA, RdAddrB/RdDataB (data registered, 1 cycle)
//   Dump      : DumpReq, DumpReady in; DumpBusy, DumpValid, DumpAddr,
//               DumpData out
// Parameters: WIDTH (data bits), AW (address bits, see addr_width()).
// -----------------------------------------------------------------------------
interface mu0_regfile_if
  import mu0_regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = addr_width(DEF_DEPTH)
);

  logic             WrEn;
  logic [AW-1:0]    WrAddr;
  logic [WIDTH-1:0] WrData;
  logic             IncEn;
  logic [AW-1:0]    IncAddr;
  logic [AW-1:0]    RdAddrA;
  logic [WIDTH-1:0] RdDataA;
  logic [AW-1:0]    RdAddrB;
  logic [WIDTH-1:0] RdDataB;
  logic             DumpReq;
  logic             DumpBusy;
  logic             DumpValid;
  logic             DumpReady;
  logic [AW-1:0]    DumpAddr;
  logic [WIDTH-1:0] DumpData;

  modport master (
    output WrEn, WrAddr, WrData, IncEn, IncAddr, RdAddrA, RdAddrB,
           DumpReq, DumpReady,
    input  RdDataA, RdDataB, DumpBusy, DumpValid, DumpAddr, DumpData
  );

  modport slave (
    input  WrEn, WrAddr, WrData, IncEn, IncAddr, RdAddrA, RdAddrB,
           DumpReq, DumpReady,
    output RdDataA, RdDataB, DumpBusy, DumpValid, DumpAddr, DumpData
  );

endinterface

// File: rtl/mu0_regfile_dump_ctrl.sv
// -----------------------------------------------------------------------------
// mu0_regfile_dump_ctrl
// Dump engine: walks registers 0..DEPTH-1 out over a valid/ready handshake.
// Each beat's data is captured when the beat is loaded, so it stays stable
// under backpressure even if that register is rewritten.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   req             : start pulse (ignored while busy)
//   ready           : consumer accepts the current beat
//   busy, valid     : dump in progress / beat valid (registered)
//   addr, data      : current beat index and snapshot data (registered)
//   rd_idx, rd_data : lookup into the register array for the next beat
// -----------------------------------------------------------------------------
module mu0_regfile_dump_ctrl
  import mu0_regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             ready,
  output logic             busy,
  output logic             valid,
  output logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] data,
  output logic [AW-1:0]    rd_idx,
  input  logic [WIDTH-1:0] rd_data
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  dump_state_t state;

  // Index of the beat that would be loaded at the next edge: register 0 when
  // starting, otherwise the one after the current beat.
  assign rd_idx = (state == DUMP) ? addr + AW'(1) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state <= DUMP;
            busy  <= 1'b1;
            valid <= 1'b1;
            addr  <= '0;
            data  <= rd_data;
          end
        end
        DUMP: begin
          // valid is always high in DUMP, so ready alone marks acceptance.
          if (ready) begin
            if (addr == LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
              valid <= 1'b0;
            end else begin
              addr <= addr + AW'(1);
              data <= rd_data;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mu0_regfile.sv
// -----------------------------------------------------------------------------
// mu0_regfile
// DEPTH x WIDTH register file replacing the discrete MU0 ACC/PC/IR registers.
// One write port, one in-place increment port (+INC_STEP, wraps), two
// registered read ports and a debug dump engine.
// Ports:
//   Clk   : clock, rising edge
//   Reset : synchronous active-high reset
//   bus   : mu0_regfile_if.slave (write/increment/read/dump signals)
// Out-of-range addresses are ignored for write/increment and read as 0.
// Write beats increment when both target the same register.
// Build option: define MU0_REGFILE_BYPASS_EN to forward a same-cycle write
// (or increment) to a matching read port; otherwise reads return the value
// held before the edge.
// -----------------------------------------------------------------------------
module mu0_regfile
  import mu0_regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int INC_STEP = DEF_INC_STEP
) (
  input  logic         Clk,
  input  logic         Reset,
  mu0_regfile_if.slave bus
);

  localparam int AW = addr_width(DEPTH);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] inc_val;
  logic [WIDTH-1:0] rd_a_val;
  logic [WIDTH-1:0] rd_b_val;
  logic [WIDTH-1:0] dump_rd_data;
  logic [AW-1:0]    dump_rd_idx;
  logic             wr_hit;
  logic             inc_hit;

  // Address decode. Looping over real entries means an out-of-range address
  // matches nothing: hits stay low and lookups return zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and a latch is never inferred.
    inc_val      = '0;
    rd_a_val     = '0;
    rd_b_val     = '0;
    dump_rd_data = '0;
    wr_hit       = 1'b0;
    inc_hit      = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.WrAddr == AW'(i))  wr_hit       = bus.WrEn;
      if (bus.IncAddr == AW'(i)) begin
        inc_hit = bus.IncEn;
        inc_val = regs[i];
      end
      if (bus.RdAddrA == AW'(i)) rd_a_val     = regs[i];
      if (bus.RdAddrB == AW'(i)) rd_b_val     = regs[i];
      if (dump_rd_idx == AW'(i)) dump_rd_data = regs[i];
    end
    inc_val = inc_val + WIDTH'(INC_STEP);
`ifdef MU0_REGFILE_BYPASS_EN
    // Increment first, write last, so a write to the same register wins.
    if (inc_hit && bus.IncAddr == bus.RdAddrA) rd_a_val = inc_val;
    if (inc_hit && bus.IncAddr == bus.RdAddrB) rd_b_val = inc_val;
    if (wr_hit && bus.WrAddr == bus.RdAddrA)   rd_a_val = bus.WrData;
    if (wr_hit && bus.WrAddr == bus.RdAddrB)   rd_b_val = bus.WrData;
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      // NOTE: the array is built from flops, not a RAM macro, and must clear
      // to zero, so every entry is reset explicitly.
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      bus.RdDataA <= '0;
      bus.RdDataB <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        // NOTE: with non-blocking assignments the last one in program order
        // takes effect, which is how the write overrides the increment.
        if (inc_hit && bus.IncAddr == AW'(i)) regs[i] <= inc_val;
        if (wr_hit && bus.WrAddr == AW'(i))   regs[i] <= bus.WrData;
      end
      bus.RdDataA <= rd_a_val;
      bus.RdDataB <= rd_b_val;
    end
  end

  mu0_regfile_dump_ctrl #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_dump_ctrl (
    .clk     (Clk),
    .rst     (Reset),
    .req     (bus.DumpReq),
    .ready   (bus.DumpReady),
    .busy    (bus.DumpBusy),
    .valid   (bus.DumpValid),
    .addr    (bus.DumpAddr),
    .data    (bus.DumpData),
    .rd_idx  (dump_rd_idx),
    .rd_data (dump_rd_data)
  );

endmodule

// File: tb/tb_mu0_regfile.sv
// -----------------------------------------------------------------------------
// tb_mu0_regfile
// Directed bench for mu0_regfile: an 8-deep instance for the main function
// and a 6-deep instance for out-of-range addresses and a non-power-of-two
// dump. Inputs change and outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_mu0_regfile;

`ifdef MU0_REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic Clk;
  logic Reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  mu0_regfile_if #(.WIDTH(16), .AW(3)) b8 ();
  mu0_regfile_if #(.WIDTH(16), .AW(3)) b6 ();

  mu0_regfile #(.WIDTH(16), .DEPTH(8), .INC_STEP(1)) u_dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (b8.slave)
  );

  mu0_regfile #(.WIDTH(16), .DEPTH(6), .INC_STEP(1)) u_dut6 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (b6.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, got no end, required end of test");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr8(input logic [2:0] a, input logic [15:0] d);
    b8.WrEn = 1'b1; b8.WrAddr = a; b8.WrData = d;
    tick();
    b8.WrEn = 1'b0;
  endtask

  task automatic wr6(input logic [2:0] a, input logic [15:0] d);
    b6.WrEn = 1'b1; b6.WrAddr = a; b6.WrData = d;
    tick();
    b6.WrEn = 1'b0;
  endtask

  task automatic check_beat8(input string tag, input int a, input logic [15:0] d);
    check({tag, "_valid"}, b8.DumpValid, 1);
    check({tag, "_busy"},  b8.DumpBusy, 1);
    check({tag, "_addr"},  b8.DumpAddr, a);
    check({tag, "_data"},  b8.DumpData, d);
  endtask

  initial begin
    logic [15:0] exp_beat [8];

    Reset = 1'b1;
    b8.WrEn = 0; b8.WrAddr = 0; b8.WrData = 0; b8.IncEn = 0; b8.IncAddr = 0;
    b8.RdAddrA = 0; b8.RdAddrB = 0; b8.DumpReq = 0; b8.DumpReady = 0;
    b6.WrEn = 0; b6.WrAddr = 0; b6.WrData = 0; b6.IncEn = 0; b6.IncAddr = 0;
    b6.RdAddrA = 0; b6.RdAddrB = 0; b6.DumpReq = 0; b6.DumpReady = 0;
    tick();
    tick();
    Reset = 1'b0;

    // ---- reset state ----
    check("rst_rda",   b8.RdDataA, 0);
    check("rst_rdb",   b8.RdDataB, 0);
    check("rst_busy",  b8.DumpBusy, 0);
    check("rst_valid", b8.DumpValid, 0);
    check("rst_daddr", b8.DumpAddr, 0);
    check("rst_ddata", b8.DumpData, 0);

    // ---- fill, then reset clears everything ----
    for (int i = 0; i < 8; i++) wr8(3'(i), 16'h1000 + 16'(i));
    b8.RdAddrA = 7; b8.RdAddrB = 0;
    tick();
    check("pre_rd7", b8.RdDataA, 16'h1007);
    check("pre_rd0", b8.RdDataB, 16'h1000);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      b8.RdAddrA = 3'(a); b8.RdAddrB = 3'(7 - a);
      tick();
      check($sformatf("rst_all_a%0d", a), b8.RdDataA, 0);
      check($sformatf("rst_all_b%0d", 7 - a), b8.RdDataB, 0);
    end
    check("rst_all_busy", b8.DumpBusy, 0);

    // ---- write/read latency and same-cycle read ----
    wr8(3, 16'hBEEF);
    b8.RdAddrA = 3;
    tick();
    check("wr_lat_r3", b8.RdDataA, 16'hBEEF);
    b8.WrEn = 1; b8.WrAddr = 3; b8.WrData = 16'h1234; b8.RdAddrA = 3;
    tick();
    b8.WrEn = 0;
    check("rbw_r3", b8.RdDataA, BYPASS ? 16'h1234 : 16'hBEEF);
    tick();
    check("after_wr_r3", b8.RdDataA, 16'h1234);
    b8.IncEn = 1; b8.IncAddr = 3; b8.RdAddrB = 3;
    tick();
    b8.IncEn = 0;
    check("rbi_r3", b8.RdDataB, BYPASS ? 16'h1235 : 16'h1234);
    tick();
    check("after_inc_r3", b8.RdDataB, 16'h1235);

    // ---- increment wrap and write-vs-increment priority ----
    wr8(1, 16'hFFFF);
    b8.IncEn = 1; b8.IncAddr = 1;
    tick();
    b8.IncEn = 0; b8.RdAddrA = 1;
    tick();
    check("inc_wrap_r1", b8.RdDataA, 16'h0000);
    b8.WrEn = 1; b8.WrAddr = 1; b8.WrData = 16'h0010; b8.IncEn = 1; b8.IncAddr = 1;
    tick();
    b8.WrEn = 0; b8.IncEn = 0;
    tick();
    check("wr_beats_inc_r1", b8.RdDataA, 16'h0010);
    b8.WrEn = 1; b8.WrAddr = 2; b8.WrData = 16'h5555; b8.IncEn = 1; b8.IncAddr = 4;
    tick();
    b8.WrEn = 0; b8.IncEn = 0; b8.RdAddrA = 2; b8.RdAddrB = 4;
    tick();
    check("wr_inc_diff_r2", b8.RdDataA, 16'h5555);
    check("wr_inc_diff_r4", b8.RdDataB, 16'h0001);

    // ---- dump with no stall ----
    for (int i = 0; i < 8; i++) wr8(3'(i), 16'(i * 16'h11));
    b8.DumpReq = 1; b8.DumpReady = 1;
    tick();
    b8.DumpReq = 0;
    for (int b = 0; b < 8; b++) begin
      check_beat8($sformatf("dump_b%0d", b), b, 16'(b * 16'h11));
      tick();
    end
    check("dump_end_busy",  b8.DumpBusy, 0);
    check("dump_end_valid", b8.DumpValid, 0);

    // ---- dump with backpressure, snapshot, ignored restart ----
    b8.DumpReq = 1;
    tick();
    b8.DumpReq = 0;
    tick();
    tick();
    check_beat8("bp_b2_pre", 2, 16'h0022);
    b8.DumpReady = 0;
    b8.WrEn = 1; b8.WrAddr = 2; b8.WrData = 16'hAAAA; b8.DumpReq = 1;
    tick();
    check_beat8("bp_stall1", 2, 16'h0022);
    b8.WrAddr = 5; b8.WrData = 16'h5A5A; b8.DumpReq = 0;
    tick();
    check_beat8("bp_stall2", 2, 16'h0022);
    b8.WrEn = 0;
    tick();
    check_beat8("bp_stall3", 2, 16'h0022);
    b8.DumpReady = 1;
    exp_beat = '{16'h0000, 16'h0011, 16'h0022, 16'h0033,
                 16'h0044, 16'h5A5A, 16'h0066, 16'h0077};
    for (int b = 2; b < 8; b++) begin
      check_beat8($sformatf("bp_b%0d", b), b, exp_beat[b]);
      tick();
    end
    check("bp_end_busy", b8.DumpBusy, 0);
    b8.RdAddrA = 2;
    tick();
    check("bp_r2_written", b8.RdDataA, 16'hAAAA);

    // ---- reset mid-dump ----
    b8.DumpReq = 1;
    tick();
    b8.DumpReq = 0;
    for (int b = 0; b < 4; b++) tick();
    check_beat8("mid_b4", 4, 16'h0044);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("mid_rst_valid", b8.DumpValid, 0);
    check("mid_rst_busy",  b8.DumpBusy, 0);
    check("mid_rst_addr",  b8.DumpAddr, 0);
    check("mid_rst_data",  b8.DumpData, 0);
    b8.RdAddrA = 5;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("mid_idle_valid%0d", c), b8.DumpValid, 0);
    end
    check("mid_rst_r5", b8.RdDataA, 0);

    // ---- DEPTH=6: out-of-range addresses and 6-beat dump ----
    wr6(7, 16'hDEAD);
    wr6(6, 16'h0606);
    wr6(5, 16'h0505);
    b6.IncEn = 1; b6.IncAddr = 7;
    tick();
    b6.IncEn = 0;
    b6.RdAddrA = 7; b6.RdAddrB = 5;
    tick();
    check("d6_rd7", b6.RdDataA, 0);
    check("d6_rd5", b6.RdDataB, 16'h0505);
    b6.RdAddrA = 6;
    tick();
    check("d6_rd6", b6.RdDataA, 0);
    b6.DumpReq = 1; b6.DumpReady = 1;
    tick();
    b6.DumpReq = 0;
    for (int b = 0; b < 6; b++) begin
      check($sformatf("d6_b%0d_valid", b), b6.DumpValid, 1);
      check($sformatf("d6_b%0d_addr", b),  b6.DumpAddr, b);
      check($sformatf("d6_b%0d_data", b),  b6.DumpData, (b == 5) ? 16'h0505 : 16'h0000);
      tick();
    end
    check("d6_end_valid", b6.DumpValid, 0);
    check("d6_end_busy",  b6.DumpBusy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
